// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI register-bank arbiter.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    localparam int   DATA_W_DEF    = 32;
    localparam int   CTRL_SEND_BIT = 0;
    localparam logic REG_SEL_DATA  = 1'b1;
    localparam logic REG_SEL_CTRL  = 1'b0;

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin pick: first eligible request at or above ptr, wrapping.
module spi_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    logic [NUM_REQ-1:0] eligible;

    assign eligible = req & ~mask;

    always_comb begin
        int k;
        winner = '0;
        valid  = 1'b0;
        k      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(ptr) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (!valid && eligible[k]) begin
                winner[k] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_arbitro_bus.sv
// Round-robin owner arbitration for the SPI register-bank port.
// Optional grant watchdog and revocation mask enabled by ARB_TIMEOUT_EN.
//
//  state | meaning
//  IDLE  | no owner; pick next requester from rr_ptr
//  GRANT | owner drives the bank port
//  DRAIN | owner released or revoked; wait for SPI transfer to finish, writes blocked
module spi_arbitro_bus
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        wr_i,
    input  logic [NUM_REQ-1:0]        reg_sel_i,
    input  logic [NUM_REQ*DATA_W-1:0] entrada_i,
    input  logic [NUM_REQ*DATA_W-1:0] addr_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [DATA_W-1:0]         salida_o,
    output logic                      timeout_o,
    input  logic                      busy_i,
    output logic                      wr_o,
    output logic                      reg_sel_o,
    output logic [DATA_W-1:0]         entrada_o,
    output logic [DATA_W-1:0]         addr_o,
    input  logic [DATA_W-1:0]         salida_i
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] mask_q;
    logic [NUM_REQ-1:0] winner;
    logic               win_valid;
    logic [PTR_W-1:0]   win_idx;
    logic               owner_req;
    logic               timeout_hit;

    spi_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req    (req_i),
        .mask   (mask_q),
        .ptr    (ptr_q),
        .winner (winner),
        .valid  (win_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (winner[k]) win_idx = PTR_W'(k);
        end
    end

    assign owner_req = |(req_i & gnt_q);

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;

    assign timeout_hit = (state_q == GRANT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (state_q == GRANT) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    // A revoked owner stays masked until its request goes low.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mask_q <= '0;
        end else begin
            mask_q <= (mask_q & req_i) | (timeout_hit ? gnt_q : '0);
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign mask_q      = '0;
`endif

    assign timeout_o = timeout_hit;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    gnt_d   = winner;
                    ptr_d   = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Watchdog wins over a request dropped in the same cycle.
                if (timeout_hit) begin
                    state_d = DRAIN;
                end else if (!owner_req) begin
                    if (busy_i) begin
                        state_d = DRAIN;
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (!busy_i) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign gnt_o    = gnt_q;
    assign salida_o = salida_i;

    always_comb begin
        wr_o      = 1'b0;
        reg_sel_o = REG_SEL_CTRL;
        entrada_o = '0;
        addr_o    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_q[k]) begin
                wr_o      = wr_i[k] & (state_q != DRAIN);
                reg_sel_o = reg_sel_i[k];
                entrada_o = entrada_i[k*DATA_W +: DATA_W];
                addr_o    = addr_i[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_spi_arbitro_bus.sv
// Self-checking bench for spi_arbitro_bus: directed scenarios plus randomized traffic
// against an ownership-level reference model. Build with ARB_TIMEOUT_EN to cover the watchdog.
module tb_spi_arbitro_bus;

    localparam int NR = 2;
    localparam int DW = 32;
    localparam int TO = 16;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic [NR-1:0]    req_i, wr_i, reg_sel_i;
    logic [NR*DW-1:0] entrada_i, addr_i;
    logic [NR-1:0]    gnt_o;
    logic [DW-1:0]    salida_o;
    logic             timeout_o;
    logic             busy_i;
    logic             wr_o, reg_sel_o;
    logic [DW-1:0]    entrada_o, addr_o, salida_i;

    spi_arbitro_bus #(
        .NUM_REQ        (NR),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .req_i     (req_i),
        .wr_i      (wr_i),
        .reg_sel_i (reg_sel_i),
        .entrada_i (entrada_i),
        .addr_i    (addr_i),
        .gnt_o     (gnt_o),
        .salida_o  (salida_o),
        .timeout_o (timeout_o),
        .busy_i    (busy_i),
        .wr_o      (wr_o),
        .reg_sel_o (reg_sel_o),
        .entrada_o (entrada_o),
        .addr_o    (addr_o),
        .salida_i  (salida_i)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_bad = 0;

    // reference model: who owns the port, whether it is draining, how long it has held
    int            m_owner;
    bit            m_drain;
    int            m_ptr;
    int            m_held;
    bit [NR-1:0]   m_mask;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_drain = 1'b0;
        m_ptr   = 0;
        m_held  = 0;
        m_mask  = '0;
    endtask

    task automatic model_step();
        bit [NR-1:0] old_mask;
        int          revoke;
        old_mask = m_mask;
        revoke   = -1;
        if (m_owner < 0) begin
            for (int i = 0; i < NR; i++) begin
                int k;
                k = (m_ptr + i) % NR;
                if (m_owner < 0 && req_i[k] && !old_mask[k]) begin
                    m_owner = k;
                    m_held  = 0;
                    m_drain = 1'b0;
                end
            end
            if (m_owner >= 0) m_ptr = (m_owner + 1) % NR;
        end else if (!m_drain) begin
            if (TO_EN && m_held == TO - 1) begin
                m_drain = 1'b1;
                revoke  = m_owner;
            end else if (!req_i[m_owner]) begin
                if (busy_i) m_drain = 1'b1;
                else        m_owner = -1;
            end
            m_held++;
        end else if (!busy_i) begin
            m_owner = -1;
        end
        if (TO_EN) begin
            m_mask = old_mask & req_i;
            if (revoke >= 0) m_mask[revoke] = 1'b1;
        end
    endtask

    task automatic check_outputs();
        logic [NR-1:0] eg;
        logic          ewr, ers, etm;
        logic [DW-1:0] eent, eadr;
        eg = '0; ewr = 1'b0; ers = 1'b0; eent = '0; eadr = '0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            ewr  = wr_i[m_owner] && !m_drain;
            ers  = reg_sel_i[m_owner];
            eent = entrada_i[m_owner*DW +: DW];
            eadr = addr_i[m_owner*DW +: DW];
        end
        etm = TO_EN && (m_owner >= 0) && !m_drain && (m_held == TO - 1);
        check_val("gnt", gnt_o, eg);
        check_val("wr", wr_o, ewr);
        check_val("reg_sel", reg_sel_o, ers);
        check_val("entrada", entrada_o, eent);
        check_val("addr", addr_o, eadr);
        check_val("salida", salida_o, salida_i);
        check_val("timeout", timeout_o, etm);
    endtask

    task automatic cycle();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_i = 1'b1;
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        check_val("rst_gnt", gnt_o, 0);
        check_val("rst_wr", wr_o, 0);
        check_val("rst_addr", addr_o, 0);
        check_val("rst_tmo", timeout_o, 0);
    endtask

    initial begin
        logic [NR-1:0]     g, prev;
        logic [NR-1:0]     order [$];
        int                own_cnt;
        int                tmo_at;

        reset_i   = 1'b1;
        req_i     = '0;
        wr_i      = '0;
        reg_sel_i = '0;
        entrada_i = '0;
        addr_i    = '0;
        busy_i    = 1'b0;
        salida_i  = 32'h1234_abcd;
        model_reset();
        do_reset();

        // first grant one cycle after request, bank port follows owner 0
        req_i = 2'b01;
        wr_i  = 2'b01;
        reg_sel_i = 2'b01;
        addr_i[0 +: DW]    = 32'h05;
        entrada_i[0 +: DW] = 32'h05;
        addr_i[DW +: DW]   = 32'h77;
        cycle();
        check_val("first_gnt", gnt_o, 2'b01);
        check_val("first_wr", wr_o, 1);
        check_val("first_addr", addr_o, 32'h05);
        check_val("first_ent", entrada_o, 32'h05);
        req_i = '0;
        wr_i  = '0;
        cycle();
        cycle();

        // two requesters, each owner releases after 4 cycles
        do_reset();
        req_i   = 2'b11;
        prev    = '0;
        own_cnt = 0;
        for (int it = 0; it < 24; it++) begin
            cycle();
            g = gnt_o;
            if (g != 0 && prev == 0) order.push_back(g);
            own_cnt = (g != 0) ? own_cnt + 1 : 0;
            req_i   = (own_cnt == 4) ? NR'(~g) : 2'b11;
            prev    = g;
        end
        while (order.size() < 3) order.push_back('0);
        check_val("rr_order0", order[0], 2'b01);
        check_val("rr_order1", order[1], 2'b10);
        check_val("rr_order2", order[2], 2'b01);
        req_i = '0;
        cycle();
        cycle();
        cycle();

        // release while SPI busy: drain holds grant with writes blocked
        do_reset();
        req_i = 2'b01;
        wr_i  = 2'b11;
        cycle();
        cycle();
        req_i  = 2'b10;
        busy_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check_val("drain_gnt", gnt_o, 2'b01);
            check_val("drain_wr", wr_o, 0);
        end
        busy_i = 1'b0;
        cycle();
        check_val("drain_dead", gnt_o, 2'b00);
        cycle();
        check_val("drain_next", gnt_o, 2'b10);
        req_i = '0;
        wr_i  = '0;
        cycle();
        cycle();

`ifdef ARB_TIMEOUT_EN
        // watchdog revokes a held grant, revoked owner masked until it toggles
        do_reset();
        req_i  = 2'b01;
        tmo_at = 0;
        cycle();
        for (int n = 2; n <= 19; n++) begin
            if (n == 5) req_i = 2'b11;
            cycle();
            if (timeout_o && tmo_at == 0) tmo_at = n;
        end
        check_val("tmo_cycle", tmo_at, 16);
        check_val("tmo_handover", gnt_o, 2'b10);
        req_i = 2'b01;
        for (int i = 0; i < 4; i++) cycle();
        check_val("tmo_masked", gnt_o, 2'b00);
        req_i = 2'b00;
        cycle();
        req_i = 2'b01;
        cycle();
        check_val("tmo_regrant", gnt_o, 2'b01);
        req_i = '0;
        cycle();
        cycle();
`endif

        // asynchronous reset mid-grant with a write pending
        do_reset();
        req_i = 2'b10;
        wr_i  = 2'b10;
        cycle();
        check_val("ares_pre_wr", wr_o, 1);
        #2;
        reset_i = 1'b1;
        model_reset();
        #1;
        check_val("ares_gnt", gnt_o, 0);
        check_val("ares_wr", wr_o, 0);
        @(negedge clk_i);
        reset_i = 1'b0;
        req_i   = 2'b11;
        cycle();
        check_val("ares_ptr0", gnt_o, 2'b01);
        req_i = '0;
        wr_i  = '0;
        cycle();
        cycle();

`ifndef ARB_TIMEOUT_EN
        // long hold never revoked without the watchdog
        do_reset();
        req_i  = 2'b01;
        tmo_at = 0;
        for (int n = 1; n <= 5000; n++) begin
            cycle();
            if (timeout_o || gnt_o != 2'b01) tmo_at++;
        end
        check_val("long_hold_bad", tmo_at, 0);
        req_i = '0;
        cycle();
        cycle();
`endif

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            for (int k = 0; k < NR; k++) begin
                if ($urandom_range(0, 7) == 0) req_i[k] = ~req_i[k];
                entrada_i[k*DW +: DW] = $urandom;
                addr_i[k*DW +: DW]    = $urandom;
            end
            wr_i      = NR'($urandom);
            reg_sel_i = NR'($urandom);
            busy_i    = ($urandom_range(0, 3) == 0);
            salida_i  = $urandom;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
